// File: rtl/timer_dev_if.sv
// Bus-side interface of the countdown timer as seen from the processor bridge.
//   Addr : word offset (0=CTRL, 1=PRESET, 2=COUNT, 3=unused)
//   WE   : write strobe, sampled at rising clk, already gated by bridge select
//   DIN  : write data
//   DOUT : combinational read data
//   IRQ  : interrupt request to CPU HWInt
interface timer_dev_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DIN;
  logic [31:0] DOUT;
  logic        IRQ;

  modport master (
    output Addr,
    output WE,
    output DIN,
    input  DOUT,
    input  IRQ
  );

  modport slave (
    input  Addr,
    input  WE,
    input  DIN,
    output DOUT,
    output IRQ
  );
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer (bridge responder).
//   clk   : single clock
//   reset : asynchronous, active-low; clears all state
//   bus   : timer_dev_if.slave (Addr, WE, DIN in; DOUT, IRQ out)
// CTRL = {IM[3], Mode[2:1], Enable[0]}; Mode 01 auto-reloads, anything else is one-shot.
module timer_dev (
  input logic         clk,
  input logic         reset,
  timer_dev_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic enable, auto_reload, im;

  assign enable      = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign im          = ctrl_q[3];

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // PRESET of 0 or 1 lands here after a single CNT cycle
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        if (auto_reload) begin
          irq_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // CPU write is applied last so it wins over the FSM for the written field
    if (bus.WE) begin
      case (bus.Addr)
        ADDR_CTRL: begin
          ctrl_d     = bus.DIN[3:0];
          irq_flag_d = 1'b0;
        end
        ADDR_PRESET: preset_d = bus.DIN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    case (bus.Addr)
      ADDR_CTRL:   bus.DOUT = {28'd0, ctrl_q};
      ADDR_PRESET: bus.DOUT = preset_q;
      ADDR_COUNT:  bus.DOUT = count_q;
      default:     bus.DOUT = 32'd0;
    endcase
  end

  // Both operands are flops, so masking takes effect on the edge that writes IM
  assign bus.IRQ = im & irq_flag_q;

endmodule

// File: tb/tb_timer_dev.sv
module tb_timer_dev;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  timer_dev_if bus ();

  timer_dev u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following the write edge.
  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = a;
    bus.DIN  = d;
    bus.WE   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.WE   = 1'b0;
    bus.DIN  = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    bus.Addr = a;
    #1;
    d = bus.DOUT;
  endtask

  logic [31:0] rd;
  logic [31:0] ar_cnt [5];

  initial begin
    n_total  = 0;
    n_bad    = 0;
    reset    = 1'b0;
    bus.Addr = 2'd0;
    bus.WE   = 1'b0;
    bus.DIN  = 32'd0;
    ar_cnt[0] = 32'd3; ar_cnt[1] = 32'd2; ar_cnt[2] = 32'd1;
    ar_cnt[3] = 32'd0; ar_cnt[4] = 32'd0;

    // Reset state
    tick(); tick();
    for (int a = 0; a < 4; a++) begin
      bus_rd(a[1:0], rd);
      check_eq($sformatf("rst_dout%0d", a), rd, 32'd0);
    end
    check_eq("rst_irq", {31'd0, bus.IRQ}, 32'd0);
    reset = 1'b1;
    tick();

    // One-shot, PRESET=5
    bus_wr(2'd1, 32'd5);
    bus_wr(2'd0, 32'h9);            // e0
    tick();                         // e1 LOAD
    for (int i = 0; i < 6; i++) begin
      tick();                       // e2..e7
      bus_rd(2'd2, rd);
      check_eq($sformatf("os_count_e%0d", i + 2), rd, 32'd5 - i);
      check_eq($sformatf("os_irq_e%0d", i + 2), {31'd0, bus.IRQ}, (i == 5) ? 32'd1 : 32'd0);
    end
    tick();                         // e8
    bus_rd(2'd0, rd);
    check_eq("os_ctrl_e8", rd, 32'h8);
    check_eq("os_irq_e8", {31'd0, bus.IRQ}, 32'd1);
    tick(); tick();
    check_eq("os_irq_hold", {31'd0, bus.IRQ}, 32'd1);
    bus_wr(2'd0, 32'h8);
    check_eq("os_irq_clr", {31'd0, bus.IRQ}, 32'd0);

    // Auto-reload, PRESET=3: pulses at e5, e10, e15, e20
    bus_wr(2'd1, 32'd3);
    bus_wr(2'd0, 32'hB);            // e0
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_eq($sformatf("ar_irq_e%0d", k), {31'd0, bus.IRQ}, (k % 5 == 0) ? 32'd1 : 32'd0);
      bus_rd(2'd2, rd);
      check_eq($sformatf("ar_cnt_e%0d", k), rd, (k == 1) ? 32'd0 : ar_cnt[(k - 2) % 5]);
    end
    bus_wr(2'd0, 32'h0);
    tick(); tick(); tick();

    // Masked run with read-only COUNT
    bus_wr(2'd1, 32'd2);
    bus_wr(2'd0, 32'h1);            // e0
    tick();                         // e1
    check_eq("mk_irq_e1", {31'd0, bus.IRQ}, 32'd0);
    tick();                         // e2
    bus_rd(2'd2, rd);
    check_eq("mk_cnt_e2", rd, 32'd2);
    bus_wr(2'd2, 32'hFFFF);         // e3
    bus_rd(2'd2, rd);
    check_eq("mk_cnt_ro", rd, 32'd1);
    check_eq("mk_irq_e3", {31'd0, bus.IRQ}, 32'd0);
    bus_wr(2'd3, 32'hFFFF);         // e4, offset 3 ignored
    bus_rd(2'd3, rd);
    check_eq("mk_off3", rd, 32'd0);
    check_eq("mk_irq_e4", {31'd0, bus.IRQ}, 32'd0);
    tick();                         // e5 IDLE
    bus_rd(2'd0, rd);
    check_eq("mk_ctrl_e5", rd, 32'h0);
    check_eq("mk_irq_e5", {31'd0, bus.IRQ}, 32'd0);
    bus_wr(2'd0, 32'h9);            // restart, e0
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq($sformatf("mk_re_irq_e%0d", k), {31'd0, bus.IRQ}, (k == 4) ? 32'd1 : 32'd0);
    end
    tick(); tick();

    // PRESET=0: INT at e3, then CTRL write on the INT edge keeps Enable and reloads
    bus_wr(2'd0, 32'h0);
    bus_wr(2'd1, 32'd0);
    bus_wr(2'd0, 32'h9);            // e0
    tick(); tick();                 // e2
    check_eq("p0_irq_e2", {31'd0, bus.IRQ}, 32'd0);
    tick();                         // e3 INT
    check_eq("p0_irq_e3", {31'd0, bus.IRQ}, 32'd1);
    bus_wr(2'd0, 32'h9);            // INT edge
    bus_rd(2'd0, rd);
    check_eq("ie_ctrl", rd, 32'h9);
    check_eq("ie_irq_clr", {31'd0, bus.IRQ}, 32'd0);
    tick(); tick();                 // IDLE->LOAD, LOAD->CNT
    check_eq("ie_irq_cnt", {31'd0, bus.IRQ}, 32'd0);
    tick();                         // CNT->INT
    check_eq("ie_irq_again", {31'd0, bus.IRQ}, 32'd1);
    tick(); tick();

    // Asynchronous reset mid-count at COUNT=7
    bus_wr(2'd0, 32'h0);
    bus_wr(2'd1, 32'd10);
    bus_wr(2'd0, 32'h9);            // e0
    for (int k = 0; k < 5; k++) tick();  // e5
    bus_rd(2'd2, rd);
    check_eq("rm_cnt7", rd, 32'd7);
    reset = 1'b0;
    #1;
    check_eq("rm_irq", {31'd0, bus.IRQ}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      bus_rd(a[1:0], rd);
      check_eq($sformatf("rm_dout%0d", a), rd, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    tick(); tick(); tick();
    bus_rd(2'd2, rd);
    check_eq("rm_idle_cnt", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
